gpu_fb_writer: RTL and testbench

Parametrised framebuffer write controller between the rasteriser pixel stream and the external asynchronous SRAM.
- Buffers incoming pixels in a small FIFO and converts (x, y) to a linear SRAM address.
- Drives multi-cycle SRAM write strobes and double-buffers the framebuffer with a drain-safe buffer swap.
- Enters SRAM sleep after a configurable idle period.
- Successor to the single-cycle memory controller: adds backpressure, FIFO depth, channel count, write-pulse timing and out-of-range rejection.

---
 rtl/gpu_fb_pkg.sv | 36 +++
 rtl/gpu_fb_fifo.sv | 52 +++++
 rtl/gpu_fb_writer.sv | 177 +++++++++++++++++
 tb/tb_gpu_fb_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared types for the framebuffer writer: FSM states and SRAM strobe patterns.
// Strobe polarities: CE1 active-high, ZZ active-low sleep, the rest active-low.
package gpu_fb_pkg;

  typedef enum logic [2:0] {
    ST_SLEEP,
    ST_WAKE,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } fb_state_t;

  typedef struct packed {
    logic ce0;
    logic ce1;
    logic lb;
    logic ub;
    logic r_w;
    logic oe;
    logic zz;
    logic sem;
  } sram_ctrl_t;

  localparam sram_ctrl_t SRAM_SLEEP = '{ce0: 1'b1, ce1: 1'b0, lb: 1'b1, ub: 1'b1,
                                        r_w: 1'b1, oe: 1'b1, zz: 1'b0, sem: 1'b1};
  localparam sram_ctrl_t SRAM_IDLE  = '{ce0: 1'b1, ce1: 1'b0, lb: 1'b1, ub: 1'b1,
                                        r_w: 1'b1, oe: 1'b1, zz: 1'b1, sem: 1'b1};
  // Chip selected, byte lanes enabled, write enable low.
  localparam sram_ctrl_t SRAM_WRITE = '{ce0: 1'b0, ce1: 1'b1, lb: 1'b0, ub: 1'b0,
                                        r_w: 1'b0, oe: 1'b1, zz: 1'b1, sem: 1'b1};
  // Chip selected with write enable high: used for address setup and data hold.
  localparam sram_ctrl_t SRAM_HOLD  = '{ce0: 1'b0, ce1: 1'b1, lb: 1'b0, ub: 1'b0,
                                        r_w: 1'b1, oe: 1'b1, zz: 1'b1, sem: 1'b1};

endpackage

// File: rtl/gpu_fb_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two.
// Push while full is honoured only when a pop happens on the same edge.
module gpu_fb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/gpu_fb_writer.sv
// Framebuffer write controller: buffers rasteriser pixels, maps (x,y) to a linear
// SRAM address in the back buffer, strobes async SRAM writes and swaps buffers on flush.
module gpu_fb_writer import gpu_fb_pkg::*; #(
  parameter int CHANNEL_BITS = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int FB_WIDTH     = 640,
  parameter int FB_HEIGHT    = 480,
  parameter int BUF_STRIDE   = 307200,
  parameter int FIFO_DEPTH   = 4,
  parameter int WAIT_CYCLES  = 1,
  parameter int SLEEP_CYCLES = 16,
  parameter int ADDR_BITS    = WIDTH_BITS + HEIGHT_BITS + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pix_valid_i,
  output logic                                 pix_ready_o,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] pix_data_i,
  input  logic [WIDTH_BITS-1:0]                pix_x_i,
  input  logic [HEIGHT_BITS-1:0]               pix_y_i,
  input  logic                                 flush_i,
  output logic                                 flush_done_o,
  output logic                                 buffer_select_o,
  output logic                                 oob_o,
  output logic                                 busy_o,
  output logic                                 CE0_o,
  output logic                                 CE1_o,
  output logic                                 LB_o,
  output logic                                 UB_o,
  output logic                                 R_W_o,
  output logic                                 OE_o,
  output logic                                 ZZ_o,
  output logic                                 SEM_o,
  output logic [ADDR_BITS-1:0]                 sram_addr_o,
  output logic [NUM_CHANNELS*CHANNEL_BITS-1:0] sram_data_o
);

  localparam int DATA_W  = NUM_CHANNELS * CHANNEL_BITS;
  localparam int ENTRY_W = WIDTH_BITS + HEIGHT_BITS + DATA_W;
  localparam int WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int IDLE_W  = (SLEEP_CYCLES > 1) ? $clog2(SLEEP_CYCLES) : 1;

  localparam logic [WIDTH_BITS:0]  FBW        = (WIDTH_BITS+1)'(FB_WIDTH);
  localparam logic [HEIGHT_BITS:0] FBH        = (HEIGHT_BITS+1)'(FB_HEIGHT);
  localparam logic [WAIT_W-1:0]    WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]    IDLE_LAST  = IDLE_W'(SLEEP_CYCLES - 1);

  fb_state_t            state, next_state;
  sram_ctrl_t           ctrl;
  logic                 rst_q;
  logic                 accept, in_range, load, swap;
  logic                 flush_pending, buf_sel, oob_q, done_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [ADDR_BITS-1:0] addr_q, lin_addr;
  logic [DATA_W-1:0]    data_q;

  logic [ENTRY_W-1:0]     fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [WIDTH_BITS-1:0]  head_x;
  logic [HEIGHT_BITS-1:0] head_y;
  logic [DATA_W-1:0]      head_data;

  assign pix_ready_o = ~rst_q & ~fifo_full & ~flush_pending;
  assign accept      = pix_valid_i & pix_ready_o;
  assign in_range    = ({1'b0, pix_x_i} < FBW) && ({1'b0, pix_y_i} < FBH);

  gpu_fb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept & in_range),
    .pop   (load),
    .wdata ({pix_x_i, pix_y_i, pix_data_i}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_x    = fifo_rdata[ENTRY_W-1 -: WIDTH_BITS];
  assign head_y    = fifo_rdata[DATA_W +: HEIGHT_BITS];
  assign head_data = fifo_rdata[DATA_W-1:0];

  // Full-width arithmetic so the largest in-range pixel of buffer 1 cannot wrap.
  assign lin_addr = ADDR_BITS'(head_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(head_x)
                  + (buf_sel ? ADDR_BITS'(BUF_STRIDE) : '0);

  // The head entry is popped and latched on the edge that enters SETUP.
  assign load = (next_state == ST_SETUP);
  assign swap = flush_pending & fifo_empty & ((state == ST_IDLE) || (state == ST_SLEEP));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SLEEP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_SLEEP:  if (!fifo_empty) next_state = ST_WAKE;
      ST_WAKE:   next_state = ST_SETUP;
      ST_IDLE: begin
        if (!fifo_empty)
          next_state = ST_SETUP;
        else if ((SLEEP_CYCLES != 0) && (idle_cnt == IDLE_LAST))
          next_state = ST_SLEEP;
      end
      ST_SETUP:  next_state = ST_STROBE;
      ST_STROBE: if (wait_cnt == WAIT_LAST) next_state = ST_HOLD;
      ST_HOLD:   next_state = fifo_empty ? ST_IDLE : ST_SETUP;
      default:   next_state = ST_SLEEP;
    endcase
  end

  always_comb begin
    ctrl = SRAM_SLEEP;
    case (state)
      ST_SLEEP:          ctrl = SRAM_SLEEP;
      ST_WAKE, ST_IDLE:  ctrl = SRAM_IDLE;
      ST_SETUP, ST_HOLD: ctrl = SRAM_HOLD;
      ST_STROBE:         ctrl = SRAM_WRITE;
      default:           ctrl = SRAM_SLEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q         <= 1'b1;
      buf_sel       <= 1'b0;
      flush_pending <= 1'b0;
      oob_q         <= 1'b0;
      done_q        <= 1'b0;
      wait_cnt      <= '0;
      idle_cnt      <= '0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      rst_q  <= 1'b0;
      oob_q  <= accept & ~in_range;
      done_q <= swap;
      // A flush arriving on the swap edge merges into the one completing now.
      if (swap) begin
        buf_sel       <= ~buf_sel;
        flush_pending <= 1'b0;
      end else if (flush_i) begin
        flush_pending <= 1'b1;
      end
      wait_cnt <= ((state == ST_STROBE) && (next_state == ST_STROBE)) ? wait_cnt + 1'b1 : '0;
      idle_cnt <= ((state == ST_IDLE) && (next_state == ST_IDLE)) ? idle_cnt + 1'b1 : '0;
      if (load) begin
        addr_q <= lin_addr;
        data_q <= head_data;
      end
    end
  end

  assign flush_done_o    = done_q;
  assign buffer_select_o = buf_sel;
  assign oob_o           = oob_q;
  assign busy_o          = ~fifo_empty | (state inside {ST_WAKE, ST_SETUP, ST_STROBE, ST_HOLD});

  assign CE0_o       = ctrl.ce0;
  assign CE1_o       = ctrl.ce1;
  assign LB_o        = ctrl.lb;
  assign UB_o        = ctrl.ub;
  assign R_W_o       = ctrl.r_w;
  assign OE_o        = ctrl.oe;
  assign ZZ_o        = ctrl.zz;
  assign SEM_o       = ctrl.sem;
  assign sram_addr_o = addr_q;
  assign sram_data_o = data_q;

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed bench for gpu_fb_writer: reset, single write, sleep, burst, range reject,
// flush/swap, reset abort and merged flush.
module tb_gpu_fb_writer;

  logic        clk = 1'b0;
  logic        rst, pix_valid_i, pix_ready_o, flush_i, flush_done_o, buffer_select_o;
  logic        oob_o, busy_o, CE0_o, CE1_o, LB_o, UB_o, R_W_o, OE_o, ZZ_o, SEM_o;
  logic [23:0] pix_data_i, sram_data_o;
  logic [9:0]  pix_x_i;
  logic [8:0]  pix_y_i;
  logic [19:0] sram_addr_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [19:0] wr_addr[$];
  logic [23:0] wr_data[$];
  int          wr_cyc[$];
  int          lo_len[$];
  logic        prev_rw = 1'b1;
  int          lo_cnt  = 0;

  logic [23:0] bdata [6] = '{24'h112233, 24'h445566, 24'h778899,
                             24'hAABBCC, 24'hDDEEFF, 24'h010203};
  logic [19:0] baddr [6] = '{20'd10, 20'd651, 20'd1292, 20'd1933, 20'd2574, 20'd3215};

  gpu_fb_writer dut (
    .clk             (clk),
    .rst             (rst),
    .pix_valid_i     (pix_valid_i),
    .pix_ready_o     (pix_ready_o),
    .pix_data_i      (pix_data_i),
    .pix_x_i         (pix_x_i),
    .pix_y_i         (pix_y_i),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .buffer_select_o (buffer_select_o),
    .oob_o           (oob_o),
    .busy_o          (busy_o),
    .CE0_o           (CE0_o),
    .CE1_o           (CE1_o),
    .LB_o            (LB_o),
    .UB_o            (UB_o),
    .R_W_o           (R_W_o),
    .OE_o            (OE_o),
    .ZZ_o            (ZZ_o),
    .SEM_o           (SEM_o),
    .sram_addr_o     (sram_addr_o),
    .sram_data_o     (sram_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: one record per falling R_W, plus the low-pulse length on the rise.
  always @(negedge clk) begin
    if (!R_W_o) begin
      if (prev_rw) begin
        wr_addr.push_back(sram_addr_o);
        wr_data.push_back(sram_data_o);
        wr_cyc.push_back(cyc);
      end
      lo_cnt <= prev_rw ? 1 : lo_cnt + 1;
    end else if (!prev_rw) begin
      lo_len.push_back(lo_cnt);
      lo_cnt <= 0;
    end
    prev_rw <= R_W_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    lo_len.delete();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int t = 0;
    while (lo_len.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, wr_addr.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy_o && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(busy_o), 0);
  endtask

  task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [23:0] d);
    pix_valid_i = 1'b1;
    pix_x_i     = x;
    pix_y_i     = y;
    pix_data_i  = d;
    @(negedge clk);
    pix_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, guard, saw_full, acc, extra;
    rst = 1'b1; pix_valid_i = 1'b0; pix_data_i = '0; pix_x_i = '0; pix_y_i = '0; flush_i = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_zz", 32'(ZZ_o), 0);
    chk("rst_ce0", 32'(CE0_o), 1);
    chk("rst_ce1", 32'(CE1_o), 0);
    chk("rst_rw", 32'(R_W_o), 1);
    chk("rst_lb_ub", 32'({LB_o, UB_o}), 3);
    chk("rst_ready", 32'(pix_ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_bufsel", 32'(buffer_select_o), 0);
    chk("rst_addr", 32'(sram_addr_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(pix_ready_o), 1);

    // Single pixel from SLEEP: SLEEP, WAKE, SETUP, STROBE, HOLD, IDLE
    clear_log();
    send(10'd5, 9'd2, 24'hABCDEF);
    chk("p1_sleep_zz", 32'(ZZ_o), 0);
    chk("p1_busy", 32'(busy_o), 1);
    @(negedge clk);
    chk("p1_wake_zz", 32'(ZZ_o), 1);
    chk("p1_wake_ce0", 32'(CE0_o), 1);
    @(negedge clk);
    chk("p1_setup_ce0", 32'(CE0_o), 0);
    chk("p1_setup_ce1", 32'(CE1_o), 1);
    chk("p1_setup_rw", 32'(R_W_o), 1);
    chk("p1_setup_addr", 32'(sram_addr_o), 1285);
    chk("p1_setup_data", 32'(sram_data_o), 32'h00ABCDEF);
    @(negedge clk);
    chk("p1_strobe_rw", 32'(R_W_o), 0);
    chk("p1_strobe_addr", 32'(sram_addr_o), 1285);
    chk("p1_strobe_data", 32'(sram_data_o), 32'h00ABCDEF);
    @(negedge clk);
    chk("p1_hold_rw", 32'(R_W_o), 1);
    chk("p1_hold_ce0", 32'(CE0_o), 0);
    chk("p1_hold_data", 32'(sram_data_o), 32'h00ABCDEF);
    @(negedge clk);
    chk("p1_idle_ce0", 32'(CE0_o), 1);
    chk("p1_idle_busy", 32'(busy_o), 0);
    chk("p1_rw_low_len", lo_len[0], 1);
    // Sleep after 16 idle cycles: ZZ falls on the 17th cycle after HOLD
    repeat (15) @(negedge clk);
    chk("sleep_zz_idle16", 32'(ZZ_o), 1);
    @(negedge clk);
    chk("sleep_zz_fall", 32'(ZZ_o), 0);

    // Burst of 6 with valid held high, starting from SLEEP
    clear_log();
    k = 0; guard = 0; saw_full = 0;
    while (k < 6 && guard < 100) begin
      pix_valid_i = 1'b1;
      pix_x_i     = 10'(10 + k);
      pix_y_i     = 9'(k);
      pix_data_i  = bdata[k];
      acc = int'(pix_ready_o);
      if (!pix_ready_o) saw_full = 1;
      @(negedge clk);
      guard++;
      if (acc != 0) k++;
    end
    pix_valid_i = 1'b0;
    chk("burst_accepted", k, 6);
    chk("burst_ready_drop", saw_full, 1);
    wait_writes("burst_wr_count", 6, 60);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_addr%0d", i), 32'(wr_addr[i]), 32'(baddr[i]));
      chk($sformatf("burst_data%0d", i), 32'(wr_data[i]), 32'(bdata[i]));
      chk($sformatf("burst_rwlen%0d", i), lo_len[i], 1);
      if (i > 0) chk($sformatf("burst_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 3);
    end

    // Out-of-range pixels are dropped
    wait_idle("oob_pre_idle", 40);
    clear_log();
    send(10'd640, 9'd0, 24'h123456);
    chk("oob_x_pulse", 32'(oob_o), 1);
    chk("oob_x_busy", 32'(busy_o), 0);
    @(negedge clk);
    chk("oob_x_clear", 32'(oob_o), 0);
    send(10'd0, 9'd480, 24'h654321);
    chk("oob_y_pulse", 32'(oob_o), 1);
    chk("oob_y_busy", 32'(busy_o), 0);
    repeat (6) @(negedge clk);
    chk("oob_no_write", wr_addr.size(), 0);

    // Flush with 3 queued pixels; flush arrives with the third
    send(10'd639, 9'd479, 24'h0000A1);
    send(10'd0, 9'd1, 24'h0000A2);
    flush_i = 1'b1;
    send(10'd3, 9'd0, 24'h0000A3);
    flush_i = 1'b0;
    chk("flush_ready_low", 32'(pix_ready_o), 0);
    chk("flush_bufsel_hold", 32'(buffer_select_o), 0);
    t = 0;
    while (!flush_done_o && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("flush_done_seen", 32'(flush_done_o), 1);
    chk("flush_bufsel", 32'(buffer_select_o), 1);
    chk("flush_wr_count", wr_addr.size(), 3);
    chk("flush_addr0", 32'(wr_addr[0]), 307199);
    chk("flush_addr1", 32'(wr_addr[1]), 640);
    chk("flush_addr2", 32'(wr_addr[2]), 3);
    @(negedge clk);
    chk("flush_done_clear", 32'(flush_done_o), 0);
    chk("flush_ready_back", 32'(pix_ready_o), 1);
    clear_log();
    send(10'd0, 9'd0, 24'hBEEF01);
    wait_writes("buf1_wr_count", 1, 40);
    chk("buf1_addr", 32'(wr_addr[0]), 307200);

    // Reset during a write aborts it and restores reset state
    wait_idle("rstw_pre_idle", 40);
    send(10'd2, 9'd0, 24'hCAFE00);
    t = 0;
    while (R_W_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rstw_in_strobe", 32'(R_W_o), 0);
    chk("rstw_addr", 32'(sram_addr_o), 307202);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ce0", 32'(CE0_o), 1);
    chk("rstw_rw", 32'(R_W_o), 1);
    chk("rstw_zz", 32'(ZZ_o), 0);
    chk("rstw_busy", 32'(busy_o), 0);
    chk("rstw_addr0", 32'(sram_addr_o), 0);
    chk("rstw_bufsel", 32'(buffer_select_o), 0);
    @(negedge clk);

    // Flush held two cycles on an empty FIFO: completes on the next edge, one toggle
    flush_i = 1'b1;
    @(negedge clk);
    chk("mflush_ready_low", 32'(pix_ready_o), 0);
    chk("mflush_no_done_yet", 32'(flush_done_o), 0);
    @(negedge clk);
    flush_i = 1'b0;
    chk("mflush_done", 32'(flush_done_o), 1);
    chk("mflush_bufsel", 32'(buffer_select_o), 1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (flush_done_o) extra++;
    end
    chk("mflush_single_pulse", extra, 0);
    chk("mflush_bufsel_stable", 32'(buffer_select_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
